// File: rtl/lfsr_region_scheduler_pkg.sv
// Shared types and constants for the LFSR region scheduler.
// Optional build macro used by the top: LFSR_SCHED_STATS_EN (run-cycle statistics).
package lfsr_sched_pkg;

  // Job-level FSM encoding (3-bit to leave room for future states)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    PAUSED = 3'd2,
    FINISH = 3'd3
  } state_e;

  // Per-core grant-sequence phase: reset_counter pulse, then start pulse
  typedef logic [1:0] phase_t;
  localparam phase_t PH_NONE  = 2'd0;  // no grant sequence in flight
  localparam phase_t PH_RESET = 2'd1;  // core_reset_cnt is high this cycle
  localparam phase_t PH_START = 2'd2;  // core_start is high this cycle

endpackage

// File: rtl/lfsr_region_scheduler_rr_arbiter.sv
// Round-robin arbiter: N_REQ requests -> one-hot grant.
// Priority rotates to the requester after the last accepted grant; clr
// re-arms the pointer so that requester 0 has top priority.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel;

  // Search starting just after the last granted index, wrapping around
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sel   = ptr_q;
    for (int off = 1; off <= N_REQ; off++) begin
      int idx;
      idx = (int'(ptr_q) + off) % N_REQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
        sel        = IDX_W'(idx);
      end
    end
  end

  // Pointer update: move to the winner only when the grant is taken
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = IDX_W'(N_REQ - 1);
    end else if (accept && valid) begin
      ptr_d = sel;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(N_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/lfsr_region_scheduler.sv
// LFSR region scheduler: hands seed regions to an array of LFSR search
// cores, one grant per cycle, and counts completed regions.
// Build macro LFSR_SCHED_STATS_EN enables the RUN-cycle counter on
// stat_run_cycles; without it that output is tied to zero.
module lfsr_region_scheduler
  import lfsr_sched_pkg::*;
#(
  parameter int N         = 32,
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic                   abort,
  input  logic                   pause_in,
  input  logic [N-1:0]           cfg_seed_base,
  input  logic [N-1:0]           cfg_seed_stride,
  input  logic [CNT_W-1:0]       cfg_num_regions,
  input  logic [NUM_CORES-1:0]   core_done,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [NUM_CORES-1:0]   core_pause,
  output logic [NUM_CORES-1:0]   core_reset_cnt,
  output logic [NUM_CORES*N-1:0] core_seed,
  output logic                   busy,
  output logic                   job_done,
  output logic [CNT_W-1:0]       regions_done,
  output logic [31:0]            stat_run_cycles
);

  state_e               state_q, state_d;
  logic [N-1:0]         stride_q, stride_d;
  logic [N-1:0]         next_seed_q, next_seed_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     regions_done_q, regions_done_d;
  logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [NUM_CORES-1:0] core_reset_cnt_q, core_reset_cnt_d;
  logic [NUM_CORES-1:0] core_pause_q, core_pause_d;
  logic                 job_done_q, job_done_d;
  phase_t               phase_q [NUM_CORES];
  phase_t               phase_d [NUM_CORES];
  logic [N-1:0]         core_seed_q [NUM_CORES];
  logic [N-1:0]         core_seed_d [NUM_CORES];

  logic                 go_ok;
  logic                 abort_ok;
  logic                 grant_en;
  logic [NUM_CORES-1:0] arb_req;
  logic [NUM_CORES-1:0] arb_grant;
  logic                 arb_valid;
  logic [NUM_CORES-1:0] grant_vec;
  logic [NUM_CORES-1:0] in_seq;
  logic [NUM_CORES-1:0] done_mask;
  logic [CNT_W+4:0]     done_cnt;
  logic [CNT_W+4:0]     done_sum;

  // A job may only be (re)started from IDLE or FINISH; abort dominates go
  assign go_ok    = go && !abort && ((state_q == IDLE) || (state_q == FINISH));
  assign abort_ok = abort && (state_q != IDLE);

  // Grants only in a clean RUN cycle while regions remain to be issued
  assign grant_en  = (state_q == RUN) && !pause_in && !abort &&
                     (issued_q < num_q) && arb_valid;
  assign arb_req   = ~core_busy_q;
  assign grant_vec = arb_grant & {NUM_CORES{grant_en}};

  rr_arbiter #(
    .N_REQ (NUM_CORES)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (go_ok),
    .req    (arb_req),
    .accept (grant_en),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  // Per-core sequence flags and completion mask
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    assign in_seq[gi]           = (phase_q[gi] != PH_NONE);
    assign done_mask[gi]        = core_done[gi] && core_busy_q[gi] && !in_seq[gi];
    assign core_seed[gi*N +: N] = core_seed_q[gi];
  end

  // Popcount of completions this cycle, then saturating add at num_regions
  always_comb begin
    done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + {{(CNT_W+4){1'b0}}, done_mask[i]};
    end
    done_sum = {5'b0, regions_done_q} + done_cnt;
  end

  // Job FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go_ok) state_d = (cfg_num_regions == '0) ? FINISH : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (pause_in) begin
          state_d = PAUSED;
        end else if ((issued_q == num_q) && (core_busy_q == '0) &&
                     (regions_done_q == num_q)) begin
          state_d = FINISH;
        end
      end
      PAUSED: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause_in) begin
          state_d = RUN;
        end
      end
      FINISH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (go_ok) begin
          state_d = (cfg_num_regions == '0) ? FINISH : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: config latch, grants, grant sequences, completions, abort
  always_comb begin
    stride_d         = stride_q;
    next_seed_d      = next_seed_q;
    num_d            = num_q;
    issued_d         = issued_q;
    regions_done_d   = regions_done_q;
    core_busy_d      = core_busy_q;
    core_start_d     = '0;
    core_reset_cnt_d = '0;
    phase_d          = phase_q;
    core_seed_d      = core_seed_q;

    if (go_ok) begin
      stride_d       = cfg_seed_stride;
      num_d          = cfg_num_regions;
      next_seed_d    = cfg_seed_base;
      issued_d       = '0;
      regions_done_d = '0;
    end else begin
      // Advance in-flight grant sequences: reset pulse -> start pulse -> done
      for (int i = 0; i < NUM_CORES; i++) begin
        if (phase_q[i] == PH_RESET) begin
          phase_d[i]      = PH_START;
          core_start_d[i] = 1'b1;
        end else if (phase_q[i] == PH_START) begin
          phase_d[i] = PH_NONE;
        end
      end

      // New grant: seed the core and kick off its sequence
      if (grant_en) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (grant_vec[i]) begin
            core_seed_d[i]      = next_seed_q;
            phase_d[i]          = PH_RESET;
            core_reset_cnt_d[i] = 1'b1;
          end
        end
        next_seed_d = next_seed_q + stride_q;
        issued_d    = issued_q + CNT_W'(1);
        core_busy_d = core_busy_q | grant_vec;
      end

      // Completions free their cores and bump the saturating count
      core_busy_d = core_busy_d & ~done_mask;
      if (done_sum > {5'b0, num_q}) begin
        regions_done_d = num_q;
      end else begin
        regions_done_d = done_sum[CNT_W-1:0];
      end

      // Abort: reset every core counter, drop pending starts, keep counters
      if (abort_ok) begin
        core_busy_d      = '0;
        core_start_d     = '0;
        core_reset_cnt_d = '1;
        for (int i = 0; i < NUM_CORES; i++) begin
          phase_d[i] = PH_NONE;
        end
      end
    end
  end

  // Registered status outputs derived from the upcoming state
  always_comb begin
    job_done_d   = (state_d == FINISH);
    core_pause_d = {NUM_CORES{state_d == PAUSED}};
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      stride_q         <= '0;
      next_seed_q      <= '0;
      num_q            <= '0;
      issued_q         <= '0;
      regions_done_q   <= '0;
      core_busy_q      <= '0;
      core_start_q     <= '0;
      core_reset_cnt_q <= '0;
      core_pause_q     <= '0;
      job_done_q       <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        phase_q[i]     <= PH_NONE;
        core_seed_q[i] <= '0;
      end
    end else begin
      state_q          <= state_d;
      stride_q         <= stride_d;
      next_seed_q      <= next_seed_d;
      num_q            <= num_d;
      issued_q         <= issued_d;
      regions_done_q   <= regions_done_d;
      core_busy_q      <= core_busy_d;
      core_start_q     <= core_start_d;
      core_reset_cnt_q <= core_reset_cnt_d;
      core_pause_q     <= core_pause_d;
      job_done_q       <= job_done_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        phase_q[i]     <= phase_d[i];
        core_seed_q[i] <= core_seed_d[i];
      end
    end
  end

  assign core_start     = core_start_q;
  assign core_reset_cnt = core_reset_cnt_q;
  assign core_pause     = core_pause_q;
  assign busy           = (state_q == RUN) || (state_q == PAUSED);
  assign job_done       = job_done_q;
  assign regions_done   = regions_done_q;

`ifdef LFSR_SCHED_STATS_EN
  logic [31:0] stat_q, stat_d;

  // RUN-cycle counter: cleared on an accepted go, saturating, frozen outside RUN
  always_comb begin
    stat_d = stat_q;
    if (go_ok) begin
      stat_d = '0;
    end else if ((state_q == RUN) && (stat_q != '1)) begin
      stat_d = stat_q + 32'd1;
    end
  end

  // Statistics register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_run_cycles = stat_q;
`else
  assign stat_run_cycles = '0;
`endif

endmodule

// File: tb/tb_lfsr_region_scheduler.sv
// Directed self-checking bench for lfsr_region_scheduler (default parameters,
// LFSR_SCHED_STATS_EN undefined).
module tb_lfsr_region_scheduler;

  localparam int N  = 32;
  localparam int NC = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go, abort, pause_in;
  logic [N-1:0]  cfg_seed_base, cfg_seed_stride;
  logic [CW-1:0] cfg_num_regions;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_start, core_pause, core_reset_cnt;
  logic [NC*N-1:0] core_seed;
  logic          busy, job_done;
  logic [CW-1:0] regions_done;
  logic [31:0]   stat_run_cycles;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int snap;

  always #5 clk = ~clk;

  lfsr_region_scheduler #(.N(N), .NUM_CORES(NC), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .go              (go),
    .abort           (abort),
    .pause_in        (pause_in),
    .cfg_seed_base   (cfg_seed_base),
    .cfg_seed_stride (cfg_seed_stride),
    .cfg_num_regions (cfg_num_regions),
    .core_done       (core_done),
    .core_start      (core_start),
    .core_pause      (core_pause),
    .core_reset_cnt  (core_reset_cnt),
    .core_seed       (core_seed),
    .busy            (busy),
    .job_done        (job_done),
    .regions_done    (regions_done),
    .stat_run_cycles (stat_run_cycles)
  );

  // Total start pulses seen, sampled mid-cycle
  always @(negedge clk) start_cnt = start_cnt + $countones(core_start);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] seed_of(input int i);
    return core_seed[i*N +: N];
  endfunction

  task automatic pulse_done(input logic [NC-1:0] m);
    core_done = m;
    step();
    core_done = '0;
  endtask

  task automatic start_job(input logic [N-1:0] b, input logic [N-1:0] s, input logic [CW-1:0] n);
    cfg_seed_base = b; cfg_seed_stride = s; cfg_num_regions = n;
    go = 1'b1;
    step();
    go = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic wait_job_done(input string tag);
    int n;
    n = 0;
    while (!job_done && n < 40) begin
      step();
      n++;
    end
    chk(tag, 64'(job_done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; pause_in = 1'b0;
    cfg_seed_base = '0; cfg_seed_stride = '0; cfg_num_regions = '0; core_done = '0;
    repeat (3) step();

    // Reset state
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_rcnt", 64'(core_reset_cnt), 64'd0);
    chk("rst_pause", 64'(core_pause), 64'd0);
    chk("rst_seed0", 64'(seed_of(0)), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_jobdone", 64'(job_done), 64'd0);
    chk("rst_regions", 64'(regions_done), 64'd0);
    chk("rst_stat", 64'(stat_run_cycles), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: base 0x1, stride 0x100, six regions, cores finish in order
    snap = start_cnt;
    start_job(32'h1, 32'h100, 16'd6);
    chk("t1_busy", 64'(busy), 64'd1);
    step(); chk("t1_seed0", 64'(seed_of(0)), 64'h1);
    chk("t1_rcnt0", 64'(core_reset_cnt), 64'b0001);
    step(); chk("t1_seed1", 64'(seed_of(1)), 64'h101);
    chk("t1_start0", 64'(core_start), 64'b0001);
    step(); chk("t1_seed2", 64'(seed_of(2)), 64'h201);
    step(); chk("t1_seed3", 64'(seed_of(3)), 64'h301);
    step();
    pulse_done(4'b0001); chk("t1_reg1", 64'(regions_done), 64'd1);
    step(); chk("t1_seed0b", 64'(seed_of(0)), 64'h401);
    pulse_done(4'b0010); chk("t1_reg2", 64'(regions_done), 64'd2);
    step(); chk("t1_seed1b", 64'(seed_of(1)), 64'h501);
    pulse_done(4'b0100);
    pulse_done(4'b1000);
    pulse_done(4'b0001);
    pulse_done(4'b0010); chk("t1_reg6", 64'(regions_done), 64'd6);
    wait_job_done("t1_jobdone");
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_starts", 64'(start_cnt - snap), 64'd6);

    // 2: abort from FINISH, then an empty job finishes immediately
    do_abort();
    chk("t2_abort_rcnt", 64'(core_reset_cnt), 64'b1111);
    chk("t2_jd_clr", 64'(job_done), 64'd0);
    snap = start_cnt;
    start_job(32'h5, 32'h1, 16'd0);
    chk("t2_jobdone", 64'(job_done), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    repeat (3) step();
    chk("t2_nostart", 64'(start_cnt - snap), 64'd0);

    // 3: pause for 10 cycles mid-job, done counted while paused
    start_job(32'h10, 32'h1, 16'd5);
    repeat (5) step();
    pause_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 4) begin
        core_done = '0;
        chk("t3_reg_paused", 64'(regions_done), 64'd1);
      end
      chk($sformatf("t3_pause_k%0d", k), 64'(core_pause), (k <= 10) ? 64'hF : 64'h0);
      if (k >= 5 && k <= 11) chk($sformatf("t3_nogrant_k%0d", k), 64'(core_reset_cnt), 64'd0);
      if (k == 5) chk("t3_busy_paused", 64'(busy), 64'd1);
      if (k == 12) begin
        chk("t3_regrant", 64'(core_reset_cnt), 64'b0001);
        chk("t3_seed0", 64'(seed_of(0)), 64'h14);
      end
      if (k == 3) core_done = 4'b0001;
      if (k == 10) pause_in = 1'b0;
    end
    step(); step();
    pulse_done(4'b0001); chk("t3_reg2", 64'(regions_done), 64'd2);
    step(); chk("t3_noissue", 64'(core_reset_cnt), 64'd0);

    // 5: abort with three cores busy
    do_abort();
    chk("t5_rcnt", 64'(core_reset_cnt), 64'b1111);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_reg_kept", 64'(regions_done), 64'd2);
    snap = start_cnt;
    step(); chk("t5_rcnt_once", 64'(core_reset_cnt), 64'd0);
    repeat (3) step();
    chk("t5_nostart", 64'(start_cnt - snap), 64'd0);

    // 4: simultaneous done on cores 0 and 2, regrants 0 then 2
    start_job(32'h0, 32'h1, 16'd8);
    repeat (5) step();
    pulse_done(4'b0101); chk("t4_reg2", 64'(regions_done), 64'd2);
    step(); chk("t4_grant0", 64'(core_reset_cnt), 64'b0001);
    chk("t4_seed0", 64'(seed_of(0)), 64'h4);
    step(); chk("t4_grant2", 64'(core_reset_cnt), 64'b0100);
    chk("t4_seed2", 64'(seed_of(2)), 64'h5);
    // go while busy must be ignored
    start_job(32'h0, 32'h1, 16'd0);
    chk("t4_go_busy", 64'(busy), 64'd1);
    chk("t4_go_jd", 64'(job_done), 64'd0);
    do_abort();

    // 6: seed wrap modulo 2^N
    start_job(32'hFFFF_FFF0, 32'h10, 16'd2);
    step(); chk("t6_seed0", 64'(seed_of(0)), 64'hFFFF_FFF0);
    step(); chk("t6_seed1", 64'(seed_of(1)), 64'h0);
    step(); step();
    pulse_done(4'b0011); chk("t6_reg2", 64'(regions_done), 64'd2);
    wait_job_done("t6_jobdone");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
